sss_peak_search: RTL and testbench

- Downstream stage of the SSS correlator.
- Consumes the stream of 32-bit correlation scores, one per candidate local SSS sequence (N_ID1 = 0..NUM_CAND-1, presented in index order).
- Tracks the best and second-best scores and their index.
- Delivers a detect/reject decision plus best index to the cell-ID combiner, with start/done handshake and a no-data timeout.

---
 rtl/sss_pkg.sv | 17 +
 rtl/sss_peak_search_if.sv | 44 ++++
 rtl/sss_top2_tracker.sv | 44 ++++
 rtl/sss_peak_search.sv | 129 ++++++++++++
 tb/tb_sss_peak_search.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/sss_pkg.sv
// Shared definitions for the SSS search blocks.
// Holds the default search dimensions and the state encoding used by
// sss_peak_search. Imported by the interface and every module of the slice.
package sss_pkg;

  localparam int NUM_SSS_CAND = 168;  // candidate local SSS sequences (N_ID1)
  localparam int SSS_LEN      = 62;   // SSS sequence length in subcarriers
  localparam int SSS_SCORE_W  = 32;   // correlation score width
  localparam int SSS_IDX_W    = 8;    // candidate index width

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_DECIDE = 2'd2
  } sss_state_t;

endpackage

// File: rtl/sss_peak_search_if.sv
// Bus between the SSS correlator / cell-ID combiner and sss_peak_search.
// Signals:
//   start       search start/restart pulse
//   threshold   minimum best score for a detection (sampled on start)
//   margin      minimum best-minus-second gap for a detection (sampled on start)
//   corr_valid  corr_score qualifier
//   corr_score  score of the current candidate, candidates in index order
//   busy        search or decision in progress
//   done        one-cycle result strobe
//   detected    threshold and margin both met
//   timeout     search aborted after too many idle cycles
//   best_idx / best_score / second_score  search result
// Modports: master drives the requests, slave is the peak search itself.
interface sss_peak_search_if
  import sss_pkg::*;
#(
  parameter int SCORE_W = SSS_SCORE_W,
  parameter int IDX_W   = SSS_IDX_W
);

  logic               start;
  logic [SCORE_W-1:0] threshold;
  logic [SCORE_W-1:0] margin;
  logic               corr_valid;
  logic [SCORE_W-1:0] corr_score;
  logic               busy;
  logic               done;
  logic               detected;
  logic               timeout;
  logic [IDX_W-1:0]   best_idx;
  logic [SCORE_W-1:0] best_score;
  logic [SCORE_W-1:0] second_score;

  modport master (
    output start, threshold, margin, corr_valid, corr_score,
    input  busy, done, detected, timeout, best_idx, best_score, second_score
  );

  modport slave (
    input  start, threshold, margin, corr_valid, corr_score,
    output busy, done, detected, timeout, best_idx, best_score, second_score
  );

endinterface

// File: rtl/sss_top2_tracker.sv
// Best / second-best score tracker with index of the best.
// Shared between the PSS and SSS searches.
// Ports:
//   clk, reset  clock, synchronous active-high reset
//   clear       zero the tracked values (new search)
//   valid       update with score/idx this cycle
//   score, idx  candidate score and its index
//   best, second, best_idx  tracked results
// Strict compares: on a tie the earlier (lower) index keeps the best slot
// and the tied score becomes the second.
module sss_top2_tracker
  import sss_pkg::*;
#(
  parameter int SCORE_W = SSS_SCORE_W,
  parameter int IDX_W   = SSS_IDX_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               valid,
  input  logic [SCORE_W-1:0] score,
  input  logic [IDX_W-1:0]   idx,
  output logic [SCORE_W-1:0] best,
  output logic [SCORE_W-1:0] second,
  output logic [IDX_W-1:0]   best_idx
);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      best     <= '0;
      second   <= '0;
      best_idx <= '0;
    end else if (valid) begin
      if (score > best) begin
        second   <= best;
        best     <= score;
        best_idx <= idx;
      end else if (score > second) begin
        second <= score;
      end
    end
  end

endmodule

// File: rtl/sss_peak_search.sv
// SSS peak search: consumes NUM_CAND correlation scores per search, tracks
// the best and second-best, then issues a detect/reject decision with a
// one-cycle done strobe. A search aborts with timeout if no score arrives
// for TIMEOUT_CYCLES consecutive cycles.
// Ports:
//   clk    clock
//   reset  synchronous, active-high reset
//   bus    sss_peak_search_if slave (start/threshold/margin/scores in,
//          busy/done/detected/timeout/result out)
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | waiting for start; scores ignored; results held
// ST_SEARCH | accepting scores, counting candidates and idle cycles
// ST_DECIDE | one cycle: evaluate threshold/margin, pulse done
module sss_peak_search
  import sss_pkg::*;
#(
  parameter int NUM_CAND       = NUM_SSS_CAND,
  parameter int SCORE_W        = SSS_SCORE_W,
  parameter int IDX_W          = SSS_IDX_W,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic               clk,
  input  logic               reset,
  sss_peak_search_if.slave   bus
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [IDX_W-1:0] LAST_CAND = IDX_W'(NUM_CAND - 1);
  localparam logic [CNT_W-1:0] LAST_IDLE = CNT_W'(TIMEOUT_CYCLES - 1);

  sss_state_t         state, next_state;
  logic [IDX_W-1:0]   cand_cnt;
  logic [CNT_W-1:0]   idle_cnt;
  logic [SCORE_W-1:0] thr_q, mar_q;
  logic               done_q, detected_q, timeout_q;
  logic [SCORE_W-1:0] best, second;
  logic [IDX_W-1:0]   best_idx;

  logic clear, accept, last_score, idle_expire;

  // Start is honoured everywhere except DECIDE; a start wins over a score.
  assign clear       = bus.start && (state != ST_DECIDE);
  assign accept      = (state == ST_SEARCH) && !bus.start && bus.corr_valid;
  assign last_score  = accept && (cand_cnt == LAST_CAND);
  assign idle_expire = (state == ST_SEARCH) && !bus.start && !bus.corr_valid &&
                       (idle_cnt == LAST_IDLE);

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:   if (bus.start) next_state = ST_SEARCH;
      ST_SEARCH: begin
        if (bus.start)        next_state = ST_SEARCH;
        else if (last_score)  next_state = ST_DECIDE;
        else if (idle_expire) next_state = ST_IDLE;
      end
      ST_DECIDE: next_state = ST_IDLE;
      default:   next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cand_cnt   <= '0;
      idle_cnt   <= '0;
      thr_q      <= '0;
      mar_q      <= '0;
      done_q     <= 1'b0;
      detected_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (clear) begin
        cand_cnt   <= '0;
        idle_cnt   <= '0;
        thr_q      <= bus.threshold;
        mar_q      <= bus.margin;
        detected_q <= 1'b0;
        timeout_q  <= 1'b0;
      end else if (state == ST_SEARCH) begin
        if (bus.corr_valid) begin
          cand_cnt <= cand_cnt + 1'b1;
          idle_cnt <= '0;
        end else if (idle_expire) begin
          done_q     <= 1'b1;
          timeout_q  <= 1'b1;
          detected_q <= 1'b0;
        end else begin
          idle_cnt <= idle_cnt + 1'b1;
        end
      end else if (state == ST_DECIDE) begin
        // best >= second by construction, so the difference cannot wrap.
        detected_q <= (best >= thr_q) && ((best - second) >= mar_q);
        done_q     <= 1'b1;
      end
    end
  end

  sss_top2_tracker #(
    .SCORE_W (SCORE_W),
    .IDX_W   (IDX_W)
  ) u_tracker (
    .clk      (clk),
    .reset    (reset),
    .clear    (clear),
    .valid    (accept),
    .score    (bus.corr_score),
    .idx      (cand_cnt),
    .best     (best),
    .second   (second),
    .best_idx (best_idx)
  );

  assign bus.busy         = (state != ST_IDLE);
  assign bus.done         = done_q;
  assign bus.detected     = detected_q;
  assign bus.timeout      = timeout_q;
  assign bus.best_idx     = best_idx;
  assign bus.best_score   = best;
  assign bus.second_score = second;

endmodule

// File: tb/tb_sss_peak_search.sv
// Directed bench for sss_peak_search with hand-computed expectations.
// The DUT runs with a 16-cycle timeout so the abort path stays short.
module tb_sss_peak_search;
  import sss_pkg::*;

  localparam int NC = NUM_SSS_CAND;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sss_peak_search_if #(.SCORE_W(SSS_SCORE_W), .IDX_W(SSS_IDX_W)) bus ();

  sss_peak_search #(
    .NUM_CAND       (NC),
    .SCORE_W        (SSS_SCORE_W),
    .IDX_W          (SSS_IDX_W),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  int lat;
  int d0;
  logic [31:0] sc [NC];

  always @(posedge clk) begin
    #1;
    if (bus.done === 1'b1) done_cnt++;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic fill(input logic [31:0] v);
    for (int i = 0; i < NC; i++) sc[i] = v;
  endtask

  task automatic fill_basic();
    fill(32'd30);
    sc[97] = 32'd60;
    sc[12] = 32'd40;
  endtask

  // Called at a negedge; returns at the negedge after the start edge.
  task automatic do_start(input logic [31:0] thr, input logic [31:0] mar);
    bus.threshold = thr;
    bus.margin    = mar;
    bus.start     = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Gaps are inserted between scores only, never after the last one.
  task automatic send_scores(input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      bus.corr_valid = 1'b1;
      bus.corr_score = sc[i];
      @(negedge clk);
      bus.corr_valid = 1'b0;
      if (i != n - 1) repeat (gap) @(negedge clk);
    end
  endtask

  task automatic wait_done(output int l);
    l = 0;
    while (bus.done !== 1'b1 && l < 100) begin
      @(negedge clk);
      l++;
    end
    if (l >= 100) check_val("wait_done_bound", {31'd0, bus.done}, 32'd1);
  endtask

  task automatic check_result(input string tag, input int idx, input int best,
                              input int second, input int det, input int to);
    check_val({tag, "_idx"},    32'(bus.best_idx),     32'(idx));
    check_val({tag, "_best"},   bus.best_score,        32'(best));
    check_val({tag, "_second"}, bus.second_score,      32'(second));
    check_val({tag, "_det"},    {31'd0, bus.detected}, 32'(det));
    check_val({tag, "_to"},     {31'd0, bus.timeout},  32'(to));
  endtask

  initial begin
    reset          = 1'b1;
    bus.start      = 1'b0;
    bus.threshold  = '0;
    bus.margin     = '0;
    bus.corr_valid = 1'b0;
    bus.corr_score = '0;
    repeat (3) @(negedge clk);
    check_val("rst_busy", {31'd0, bus.busy}, 32'd0);
    check_val("rst_done", {31'd0, bus.done}, 32'd0);
    check_result("rst", 0, 0, 0, 0, 0);
    reset = 1'b0;
    @(negedge clk);

    // basic detection, latency and single-cycle done
    fill_basic();
    do_start(32'd50, 32'd5);
    check_val("basic_busy", {31'd0, bus.busy}, 32'd1);
    send_scores(NC, 0);
    wait_done(lat);
    check_val("basic_lat", 32'(lat), 32'd1);
    check_result("basic", 97, 60, 40, 1, 0);
    @(negedge clk);
    check_val("basic_done_low", {31'd0, bus.done}, 32'd0);
    check_val("basic_idle", {31'd0, bus.busy}, 32'd0);

    // stray scores in IDLE are dropped
    d0 = done_cnt;
    bus.corr_valid = 1'b1;
    bus.corr_score = 32'd1000;
    repeat (3) @(negedge clk);
    bus.corr_valid = 1'b0;
    check_val("excess_busy", {31'd0, bus.busy}, 32'd0);
    check_val("excess_best", bus.best_score, 32'd60);
    check_val("excess_done", 32'(done_cnt - d0), 32'd0);

    // margin fail
    fill(32'd10);
    sc[5]   = 32'd55;
    sc[150] = 32'd52;
    do_start(32'd50, 32'd5);
    send_scores(NC, 0);
    wait_done(lat);
    check_val("margin_lat", 32'(lat), 32'd1);
    check_result("margin", 5, 55, 52, 0, 0);
    @(negedge clk);

    // tie: lowest index wins, zero margin accepted
    fill(32'd0);
    sc[20] = 32'd62;
    sc[21] = 32'd62;
    do_start(32'd62, 32'd0);
    send_scores(NC, 0);
    wait_done(lat);
    check_result("tie", 20, 62, 62, 1, 0);
    @(negedge clk);

    // gapped valid, best == threshold and gap == margin exactly
    fill_basic();
    do_start(32'd60, 32'd20);
    send_scores(NC, 3);
    wait_done(lat);
    check_val("gap_lat", 32'(lat), 32'd1);
    check_result("gap", 97, 60, 40, 1, 0);
    @(negedge clk);

    // threshold one above best, margin one above gap
    do_start(32'd61, 32'd0);
    send_scores(NC, 0);
    wait_done(lat);
    check_result("thr_fail", 97, 60, 40, 0, 0);
    @(negedge clk);
    do_start(32'd0, 32'd21);
    send_scores(NC, 0);
    wait_done(lat);
    check_result("mar_fail", 97, 60, 40, 0, 0);
    @(negedge clk);

    // timeout after 40 scores: partial results held
    fill_basic();
    do_start(32'd50, 32'd5);
    send_scores(40, 0);
    wait_done(lat);
    check_val("to_lat", 32'(lat), 32'(TO));
    check_result("to", 12, 40, 30, 0, 1);
    @(negedge clk);
    check_val("to_idle", {31'd0, bus.busy}, 32'd0);

    // restart mid-search; score presented with start is ignored
    fill(32'd100);
    do_start(32'd0, 32'd0);
    send_scores(70, 0);
    d0 = done_cnt;
    fill_basic();
    bus.corr_valid = 1'b1;
    bus.corr_score = 32'd1000;
    do_start(32'd50, 32'd5);
    send_scores(NC, 0);
    wait_done(lat);
    check_result("restart", 97, 60, 40, 1, 0);
    check_val("restart_dones", 32'(done_cnt - d0), 32'd1);
    @(negedge clk);

    // reset mid-search
    d0 = done_cnt;
    fill(32'd7);
    do_start(32'd3, 32'd3);
    send_scores(50, 0);
    reset = 1'b1;
    @(negedge clk);
    check_val("rstmid_busy", {31'd0, bus.busy}, 32'd0);
    check_val("rstmid_done", {31'd0, bus.done}, 32'd0);
    check_result("rstmid", 0, 0, 0, 0, 0);
    reset = 1'b0;
    repeat (TO + 10) @(negedge clk);
    check_val("rstmid_nodone", 32'(done_cnt - d0), 32'd0);
    check_val("rstmid_idle", {31'd0, bus.busy}, 32'd0);

    // back-to-back: start coincident with done
    fill_basic();
    do_start(32'd50, 32'd5);
    send_scores(NC, 0);
    wait_done(lat);
    check_result("b2b_first", 97, 60, 40, 1, 0);
    d0 = done_cnt;
    fill(32'd0);
    sc[20] = 32'd62;
    sc[21] = 32'd62;
    do_start(32'd62, 32'd0);
    check_val("b2b_busy", {31'd0, bus.busy}, 32'd1);
    check_val("b2b_cleared", bus.best_score, 32'd0);
    send_scores(NC, 0);
    wait_done(lat);
    check_result("b2b_second", 20, 62, 62, 1, 0);
    @(negedge clk);
    check_val("b2b_dones", 32'(done_cnt - d0), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
